// File: rtl/memory_access_stage_if.sv
// D-cache request/response channel between the MEM stage (master) and the data cache (slave).
interface memory_access_stage_if #(
    parameter int ADDR_W = 64
);
    logic              dcache_req_valid;
    logic              dcache_req_ready;
    logic [ADDR_W-1:0] dcache_addr;
    logic              dcache_we;
    logic [ADDR_W-1:0] dcache_wdata;
    logic [7:0]        dcache_wstrb;
    logic              dcache_resp_valid;
    logic [ADDR_W-1:0] dcache_resp_data;

    modport master (
        output dcache_req_valid, dcache_addr, dcache_we, dcache_wdata, dcache_wstrb,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_data
    );

    modport slave (
        input  dcache_req_valid, dcache_addr, dcache_we, dcache_wdata, dcache_wstrb,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_data
    );
endinterface

// File: rtl/memory_access_stage.sv
// RV64 MEM stage: issues loads/stores to the D-cache and forwards write-back data downstream.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of reaching the cache.
package memory_access_stage_pkg;
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       reg_write;
    } control_signals_struct;
endpackage

module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic [ADDR_W-1:0]     alu_data_in,
    input  logic [ADDR_W-1:0]     store_data_in,
    input  control_signals_struct control_signals,
    output logic                  busy,
    memory_access_stage_if.master dc,
    output logic [ADDR_W-1:0]     mem_data_out,
    output logic [ADDR_W-1:0]     alu_data_out,
    output control_signals_struct control_signals_out,
    output logic                  misaligned_fault,
    output logic                  memory_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     alu_q, alu_d;
    logic [ADDR_W-1:0]     store_q, store_d;
    control_signals_struct ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]     mem_data_q, mem_data_d;
    logic                  fault_q, fault_d;

    logic [2:0]        off;
    logic [7:0]        size_mask;
    logic [15:0]       strb_wide;
    logic [ADDR_W-1:0] raw;
    logic [ADDR_W-1:0] load_ext;
    logic              sext;
    logic              in_is_mem;

    assign off       = alu_q[2:0];
    assign sext      = ~ctrl_q.funct3[2];
    assign in_is_mem = (control_signals.opcode == OP_LOAD) || (control_signals.opcode == OP_STORE);

    always_comb begin
        case (ctrl_q.funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Bytes past the doubleword fall off the top of the wide shift, and the
    // logical right shift brings in zeros for load bytes beyond it.
    assign strb_wide = {8'h00, size_mask} << off;
    assign raw       = dc.dcache_resp_data >> {off, 3'b000};

    always_comb begin
        case (ctrl_q.funct3[1:0])
            2'd0:    load_ext = {{56{sext & raw[7]}},  raw[7:0]};
            2'd1:    load_ext = {{48{sext & raw[15]}}, raw[15:0]};
            2'd2:    load_ext = {{32{sext & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic [2:0] in_size_m1;
    logic       in_misaligned;

    always_comb begin
        case (control_signals.funct3[1:0])
            2'd0:    in_size_m1 = 3'd0;
            2'd1:    in_size_m1 = 3'd1;
            2'd2:    in_size_m1 = 3'd3;
            default: in_size_m1 = 3'd7;
        endcase
    end

    assign in_misaligned = |(alu_data_in[2:0] & in_size_m1);
`endif

    always_comb begin
        state_d    = state_q;
        alu_d      = alu_q;
        store_d    = store_q;
        ctrl_d     = ctrl_q;
        mem_data_d = mem_data_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (mem_enable) begin
                    alu_d      = alu_data_in;
                    store_d    = store_data_in;
                    ctrl_d     = control_signals;
                    mem_data_d = '0;
                    fault_d    = 1'b0;
                    state_d    = S_DONE;
                    if (in_is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (in_misaligned) fault_d = 1'b1;
                        else               state_d = S_REQ;
`else
                        state_d = S_REQ;
`endif
                    end
                end
            end
            S_REQ: begin
                if (dc.dcache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dc.dcache_resp_valid) begin
                    if (ctrl_q.opcode == OP_LOAD) mem_data_d = load_ext;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            alu_q      <= '0;
            store_q    <= '0;
            ctrl_q     <= '0;
            mem_data_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_q      <= alu_d;
            store_q    <= store_d;
            ctrl_q     <= ctrl_d;
            mem_data_q <= mem_data_d;
            fault_q    <= fault_d;
        end
    end

    // Request fields are only driven while a request is presented.
    always_comb begin
        dc.dcache_req_valid = (state_q == S_REQ);
        dc.dcache_addr      = '0;
        dc.dcache_we        = 1'b0;
        dc.dcache_wdata     = '0;
        dc.dcache_wstrb     = '0;
        if (state_q == S_REQ) begin
            dc.dcache_addr  = {alu_q[ADDR_W-1:3], 3'b000};
            dc.dcache_we    = (ctrl_q.opcode == OP_STORE);
            dc.dcache_wdata = store_q << {off, 3'b000};
            dc.dcache_wstrb = strb_wide[7:0];
        end
    end

    assign busy                = (state_q != S_IDLE);
    assign memory_done         = (state_q == S_DONE);
    assign mem_data_out        = mem_data_q;
    assign alu_data_out        = alu_q;
    assign control_signals_out = ctrl_q;
    assign misaligned_fault    = fault_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed table, random ops vs. byte-level model, reset corner.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic mem_enable;
    logic [63:0] alu_data_in, store_data_in;
    control_signals_struct control_signals;
    logic busy, misaligned_fault, memory_done;
    logic [63:0] mem_data_out, alu_data_out;
    control_signals_struct control_signals_out;

    memory_access_stage_if dif();

    memory_access_stage dut (
        .clk(clk), .reset(reset), .mem_enable(mem_enable),
        .alu_data_in(alu_data_in), .store_data_in(store_data_in),
        .control_signals(control_signals), .busy(busy), .dc(dif),
        .mem_data_out(mem_data_out), .alu_data_out(alu_data_out),
        .control_signals_out(control_signals_out),
        .misaligned_fault(misaligned_fault), .memory_done(memory_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] addr, st, resp;
        int          rdy, rsp;
        bit          junk;
        logic [63:0] e_mem;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        bit          e_we, e_req, e_fault;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-by-byte reference of what the stage should do for one op.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] st, input logic [63:0] resp,
                                  output logic [63:0] m, output logic [7:0] strb, output logic [63:0] wd,
                                  output bit we, output bit req, output bit fault);
        int sz, off;
        bit ld, sto, s;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        off = int'(addr[2:0]);
        ld = (op == 7'b0000011);
        sto = (op == 7'b0100011);
        fault = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        fault = (ld || sto) && ((off % sz) != 0);
`endif
        req = (ld || sto) && !fault;
        we = sto && req;
        strb = '0; wd = '0; m = '0; v = '0;
        if (req) begin
            for (int b = 0; b < 8; b++) begin
                if (b >= off) begin
                    wd[8*b +: 8] = st[8*(b-off) +: 8];
                    if (b < off + sz) strb[b] = 1'b1;
                end
            end
        end
        if (ld && req) begin
            for (int i = 0; i < sz; i++)
                if (off + i < 8) v[8*i +: 8] = resp[8*(off+i) +: 8];
            s = !f3[2] && v[8*sz-1];
            for (int i = sz; i < 8; i++) v[8*i +: 8] = s ? 8'hFF : 8'h00;
            m = v;
        end
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] st, input logic [63:0] resp, input int rdy, input int rsp,
                                input bit junk, input logic [63:0] e_mem, input logic [7:0] e_strb,
                                input logic [63:0] e_wdata, input bit e_we, input bit e_req, input bit e_fault);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.st = st; v.resp = resp;
        v.rdy = rdy; v.rsp = rsp; v.junk = junk;
        v.e_mem = e_mem; v.e_strb = e_strb; v.e_wdata = e_wdata;
        v.e_we = e_we; v.e_req = e_req; v.e_fault = e_fault;
        return v;
    endfunction

    // Plays the upstream stage and the cache for one op; called and returns at a negedge.
    task automatic run_op(input vec_t v, input string tag);
        control_signals_struct cs;
        bit seen, done, hs, stable;
        int lat, low, hs_at, e_lat;
        logic [63:0] c_addr, c_wd;
        logic [7:0] c_strb;
        logic c_we;
        seen = 0; done = 0; hs = 0; stable = 1; lat = 0; low = 0; hs_at = 0;
        c_addr = '0; c_wd = '0; c_strb = '0; c_we = 1'b0;
        e_lat = v.e_req ? 3 + v.rdy + v.rsp : 1;
        chk({tag, " idle_before"}, 64'(busy), 64'd0);
        cs.opcode = v.op; cs.funct3 = v.f3; cs.rd = 5'($urandom); cs.reg_write = 1'($urandom);
        mem_enable = 1'b1; alu_data_in = v.addr; store_data_in = v.st; control_signals = cs;
        dif.dcache_resp_valid = v.junk;
        dif.dcache_resp_data = {$urandom, $urandom};
        @(negedge clk);
        for (int k = 1; k <= 40 && !done; k++) begin
            dif.dcache_req_ready = 1'b0;
            dif.dcache_resp_valid = 1'b0;
            if (memory_done) begin
                done = 1; lat = k;
            end else if (dif.dcache_req_valid) begin
                if (!seen) begin
                    c_addr = dif.dcache_addr; c_we = dif.dcache_we;
                    c_wd = dif.dcache_wdata; c_strb = dif.dcache_wstrb;
                end else if (c_addr !== dif.dcache_addr || c_we !== dif.dcache_we ||
                             c_wd !== dif.dcache_wdata || c_strb !== dif.dcache_wstrb) begin
                    stable = 0;
                end
                seen = 1;
                if (low < v.rdy) low++;
                else begin
                    dif.dcache_req_ready = 1'b1; hs = 1; hs_at = k;
                    if (v.junk) begin
                        dif.dcache_resp_valid = 1'b1; dif.dcache_resp_data = ~v.resp;
                    end
                end
            end else if (hs && k == hs_at + 1 + v.rsp) begin
                dif.dcache_resp_valid = 1'b1; dif.dcache_resp_data = v.resp;
            end
            if (done) begin
                mem_enable = 1'b0;
            end else begin
                mem_enable = v.junk ? 1'($urandom) : 1'b0;
                if (v.junk) begin
                    alu_data_in = {$urandom, $urandom}; store_data_in = {$urandom, $urandom};
                    control_signals = control_signals_struct'($urandom);
                end
                @(negedge clk);
            end
        end
        mem_enable = 1'b0;
        chk({tag, " done_seen"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(e_lat));
        chk({tag, " mem_data_out"}, mem_data_out, v.e_mem);
        chk({tag, " alu_data_out"}, alu_data_out, v.addr);
        chk({tag, " ctrl_out"}, 64'(control_signals_out), 64'(cs));
        chk({tag, " misaligned_fault"}, 64'(misaligned_fault), 64'(v.e_fault));
        chk({tag, " req_issued"}, 64'(seen), 64'(v.e_req));
        if (v.e_req) begin
            chk({tag, " addr"}, c_addr, v.addr & ~64'h7);
            chk({tag, " we"}, 64'(c_we), 64'(v.e_we));
            chk({tag, " wstrb"}, 64'(c_strb), 64'(v.e_strb));
            chk({tag, " wdata"}, c_wd, v.e_wdata);
            chk({tag, " req_stable"}, 64'(stable), 64'd1);
        end
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(memory_done), 64'd0);
        chk({tag, " idle_after"}, 64'(busy), 64'd0);
        chk({tag, " mem_data_hold"}, mem_data_out, v.e_mem);
    endtask

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011, ALUI = 7'b0010011;

    vec_t tbl[$];
    vec_t rv;

    initial begin
        reset = 1'b1; mem_enable = 1'b0; alu_data_in = '0; store_data_in = '0; control_signals = '0;
        dif.dcache_req_ready = 1'b0; dif.dcache_resp_valid = 1'b0; dif.dcache_resp_data = '0;

        tbl.push_back(mk(LD, 3'b011, 64'h1008, 64'h0, 64'h1122334455667788, 0, 0, 0,
                         64'h1122334455667788, 8'hFF, 64'h0, 0, 1, 0));
        tbl.push_back(mk(LD, 3'b000, 64'h1003, 64'h0, 64'h0000000080000000, 0, 0, 0,
                         64'hFFFFFFFFFFFFFF80, 8'h08, 64'h0, 0, 1, 0));
        tbl.push_back(mk(LD, 3'b100, 64'h1003, 64'h0, 64'h0000000080000000, 0, 1, 1,
                         64'h80, 8'h08, 64'h0, 0, 1, 0));
        tbl.push_back(mk(ST, 3'b001, 64'h2006, 64'hABCD, 64'h0, 1, 2, 1,
                         64'h0, 8'hC0, 64'hABCD000000000000, 1, 1, 0));
        tbl.push_back(mk(ALU, 3'b000, 64'h42, 64'h0, 64'h0, 0, 0, 0,
                         64'h0, 8'h00, 64'h0, 0, 0, 0));
        tbl.push_back(mk(LD, 3'b010, 64'h1008, 64'h0, 64'h00000000FFFF8000, 4, 0, 1,
                         64'hFFFFFFFFFFFF8000, 8'h0F, 64'h0, 0, 1, 0));
        tbl.push_back(mk(ST, 3'b011, 64'h3000, 64'h0123456789ABCDEF, 64'h0, 0, 0, 0,
                         64'h0, 8'hFF, 64'h0123456789ABCDEF, 1, 1, 0));
        tbl.push_back(mk(LD, 3'b101, 64'h100E, 64'h0, 64'hBEEF000000000000, 2, 3, 0,
                         64'hBEEF, 8'hC0, 64'h0, 0, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        tbl.push_back(mk(LD, 3'b010, 64'h1002, 64'h0, 64'h8877665544332211, 0, 0, 0,
                         64'h0, 8'h00, 64'h0, 0, 0, 1));
        tbl.push_back(mk(LD, 3'b010, 64'h1006, 64'h0, 64'h8877665544332211, 0, 0, 0,
                         64'h0, 8'h00, 64'h0, 0, 0, 1));
        tbl.push_back(mk(ST, 3'b010, 64'h2005, 64'hDEADBEEF, 64'h0, 0, 0, 0,
                         64'h0, 8'h00, 64'h0, 0, 0, 1));
`else
        tbl.push_back(mk(LD, 3'b010, 64'h1002, 64'h0, 64'h8877665544332211, 0, 0, 0,
                         64'h66554433, 8'h3C, 64'h0, 0, 1, 0));
        tbl.push_back(mk(LD, 3'b010, 64'h1006, 64'h0, 64'h8877665544332211, 0, 0, 0,
                         64'h8877, 8'hC0, 64'h0, 0, 1, 0));
        tbl.push_back(mk(ST, 3'b010, 64'h2005, 64'hDEADBEEF, 64'h0, 0, 0, 0,
                         64'h0, 8'hE0, 64'hADBEEF0000000000, 1, 1, 0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst req_valid", 64'(dif.dcache_req_valid), 64'd0);
        chk("rst mem_data_out", mem_data_out, 64'd0);
        chk("rst alu_data_out", alu_data_out, 64'd0);
        chk("rst ctrl_out", 64'(control_signals_out), 64'd0);
        chk("rst done", 64'(memory_done), 64'd0);
        chk("rst fault", 64'(misaligned_fault), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a load response
        mem_enable = 1'b1; alu_data_in = 64'h1010; store_data_in = '0;
        control_signals = '{opcode: LD, funct3: 3'b011, rd: 5'd3, reg_write: 1'b1};
        @(negedge clk);
        mem_enable = 1'b0;
        chk("rstmid in_req", 64'(dif.dcache_req_valid), 64'd1);
        dif.dcache_req_ready = 1'b1;
        @(negedge clk);
        dif.dcache_req_ready = 1'b0;
        chk("rstmid in_wait", 64'(busy && !dif.dcache_req_valid && !memory_done), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid busy", 64'(busy), 64'd0);
        chk("rstmid req_valid", 64'(dif.dcache_req_valid), 64'd0);
        chk("rstmid mem_data", mem_data_out, 64'd0);
        chk("rstmid alu_out", alu_data_out, 64'd0);
        chk("rstmid ctrl_out", 64'(control_signals_out), 64'd0);
        dif.dcache_resp_valid = 1'b1; dif.dcache_resp_data = 64'hDEADDEADDEADDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_resp done", 64'(memory_done), 64'd0);
            chk("late_resp busy", 64'(busy), 64'd0);
            chk("late_resp mem_data", mem_data_out, 64'd0);
        end
        dif.dcache_resp_valid = 1'b0;
        @(negedge clk);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            rv.op = (sel == 0) ? LD : (sel == 1) ? ST : (sel == 2) ? ALU : ALUI;
            rv.f3 = 3'($urandom);
            if (rv.op == ST) rv.f3[2] = 1'b0;
            rv.addr = {$urandom, $urandom};
            rv.st = {$urandom, $urandom};
            rv.resp = {$urandom, $urandom};
            rv.rdy = $urandom_range(0, 3);
            rv.rsp = $urandom_range(0, 3);
            rv.junk = 1'($urandom);
            model(rv.op, rv.f3, rv.addr, rv.st, rv.resp,
                  rv.e_mem, rv.e_strb, rv.e_wdata, rv.e_we, rv.e_req, rv.e_fault);
            run_op(rv, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
